// File: rtl/uart_rx_param_pkg.sv
// uart_rx_param_pkg: shared UART constants, receiver state encoding and baud divider computation
package uart_rx_param_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} rx_state_t;
  // Rounded clk_freq / (baud_rate * oversample): 50 MHz, 115200 x16 -> 27
  function automatic int baud_div(input int clk_freq, input int baud_rate, input int oversample);
    return (clk_freq + baud_rate * oversample / 2) / (baud_rate * oversample);
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversampling tick generator shared by the UART RX and TX
//   clk_50m in  system clock
//   rst     in  asynchronous reset, active-high
//   clr     in  holds the divider at 0; first tick comes DIV cycles after clr drops
//   tick    out one-cycle pulse every DIV cycles
module uart_baud_tick
  import uart_rx_param_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk_50m,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk_50m or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clr || cnt == LAST) ? '0 : cnt + 1'b1;
  assign tick = !clr && cnt == LAST;
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receiver with majority vote and valid/ready output
//   clk_50m in  system clock          rst  in  asynchronous reset, active-high
//   rx      in  serial line, idle 1   ready in consumer accepts on valid&ready
//   data    out payload               valid out payload held until accepted
//   frame_err/parity_err out flags qualified by valid
//   overrun out sticky, frame dropped while valid; cleared by handshake
//   busy    out receiver not idle
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] S_A   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_B   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_DEC = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] NBITS = BW'(DATA_BITS);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  logic [1:0]           rx_sync;
  rx_state_t            state;
  logic [SW-1:0]        s;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 m0, m1, pbit, ferr, stop_n, tick;
  logic                 rxs, maj, dec, last, stop_bad, perr, deliver, clr;
  assign rxs      = rx_sync[1];
  assign maj      = (m0 & m1) | (m0 & rxs) | (m1 & rxs);
  assign dec      = tick && s == S_DEC;
  assign last     = tick && s == S_END;
  assign stop_bad = ferr | ~maj;
  assign perr     = (PARITY != PARITY_NONE) && ((^{shreg, pbit}) ^ (PARITY == PARITY_ODD));
  assign deliver  = state == STOP && dec && stop_n == LAST_STOP;
  assign clr      = state == IDLE;
  assign busy     = state != IDLE;
  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk_50m(clk_50m),
    .rst    (rst),
    .clr    (clr),
    .tick   (tick)
  );
  always_ff @(posedge clk_50m or posedge rst)
    if (rst) begin
      rx_sync    <= 2'b11;
      state      <= IDLE;
      s          <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      m0         <= 1'b1;
      m1         <= 1'b1;
      pbit       <= 1'b0;
      ferr       <= 1'b0;
      stop_n     <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      if (tick) begin
        s <= last ? '0 : s + 1'b1;
        if (s == S_A) m0 <= rxs;
        if (s == S_B) m1 <= rxs;
      end
      case (state)
        IDLE: if (!rxs) begin
          state  <= START;
          s      <= '0;
          bcnt   <= '0;
          ferr   <= 1'b0;
          stop_n <= 1'b0;
        end
        START: if (dec && maj) state <= IDLE;
          else if (last) state <= DATA;
        DATA: begin
          if (dec) begin
            shreg <= {maj, shreg[DATA_BITS-1:1]};
            bcnt  <= bcnt + 1'b1;
          end
          if (last && bcnt == NBITS) state <= PARITY != PARITY_NONE ? PAR : STOP;
        end
        PAR: begin
          if (dec) pbit <= maj;
          if (last) state <= STOP;
        end
        STOP: if (dec) begin
          ferr   <= stop_bad;
          stop_n <= stop_n + 1'b1;
          // Leave at the last decision, not the period end, so a back-to-back start edge is not missed
          if (stop_n == LAST_STOP) state <= stop_bad ? BRK : IDLE;
        end
        BRK: if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (valid && ready) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
      if (deliver) begin
        if (!valid || ready) begin
          data       <= shreg;
          frame_err  <= stop_bad;
          parity_err <= perr;
          valid      <= 1'b1;
        end else overrun <= 1'b1;
      end
    end
endmodule
